mem_read_stage: RTL and testbench
=================================

# mem_read_stage

Consumes the 32-bit address stream produced by the scan-based address generator and turns it into an ordered stream of data words read from a single-port synchronous SRAM. It sits directly downstream of the address generator and upstream of the compute datapath. It applies valid/ready backpressure toward the generator and flags out-of-range addresses without issuing a memory read.

## Interface
- ADDR_W, 32: width of incoming address.
- MEM_ADDR_W, 10: SRAM address width; valid range is 0 .. 2^MEM_ADDR_W-1.
- DATA_W, 16: SRAM and output data width.
- DEPTH, 4: output FIFO entries, power of two, ≥2.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  address beat valid.
- in_addr  in  ADDR_W  address from generator.
- in_ready  out  1  stage can accept an address this cycle.
- mem_ren  out  1  SRAM read enable.
- mem_raddr  out  MEM_ADDR_W  SRAM read address.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_ren.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  read data (0 for error beats).
- out_err  out  1  beat came from an out-of-range address.
- out_ready  in  1  consumer accepts beat.
- err_sticky  out  1  set on first out-of-range accept, cleared only by rst.
- beat_count  out  32  number of output beats popped since reset, wraps mod 2^32.

## Operation
- Accept: in_valid && in_ready. in_ready = !rst && (fifo_count + inflight_v) < DEPTH. It is driven from registers only, with no combinational path from out_ready.
- Range check on accept: in range iff in_addr[ADDR_W-1:MEM_ADDR_W] == 0.
- In range: mem_ren=1, mem_raddr=in_addr[MEM_ADDR_W-1:0] in the accept cycle (combinational from in_addr).
- Out of range: mem_ren=0, err_sticky set next cycle.
- mem_ren=0 whenever no accept occurs.
- In-flight register (inflight_v, inflight_err) loads on every cycle: v=accept, err=accept && !in_range.
- FIFO write when inflight_v: entry = {inflight_err ? 0 : mem_rdata, inflight_err}. Order of accepted addresses is preserved, including error beats.
- FIFO pop when out_valid && out_ready. out_valid = fifo_count != 0, and out_data/out_err show the head entry. beat_count increments on each pop.
- Simultaneous push and pop: fifo_count is unchanged. Push into a full FIFO cannot occur because of the credit rule. Pop on empty is ignored.
- Width rules: fifo_count is log2(DEPTH)+1 bits. Read and write pointers wrap mod DEPTH.

## Timing
- Reset values: in_ready=0 while rst is high, mem_ren=0, out_valid=0, out_data=0, out_err=0, err_sticky=0, beat_count=0, inflight_v=0, FIFO empty.
- First cycle after rst deasserts: in_ready=1.
- Latency: address accepted in cycle N → SRAM data captured at end of N+1 → out_valid high in cycle N+2.
- Throughput: one beat per cycle sustained with out_ready held high. Occupancy+inflight settles at 2, which is less than DEPTH.
- Backpressure: with out_ready low, the stage accepts exactly DEPTH addresses, then in_ready drops. In_ready reasserts the cycle after the first pop that frees a credit.
- Reset mid-operation: in-flight read and FIFO contents are discarded. No output beat for them is ever produced.

## Test plan
- Reset, then stream addresses 0,1,2,…,15 with in_valid=1 and out_ready=1, with SRAM preloaded mem[i]=i+0x100. Expect out_data 0x100..0x10F, first out_valid 2 cycles after first accept, one beat per cycle, out_err=0, beat_count=16.
- out_ready=0, in_valid=1 continuously. Expect exactly 4 accepts, then in_ready=0 and out_valid=1 holding head 0x100. Raise out_ready for 1 cycle: one pop, and in_ready=1 the next cycle.
- Addresses 5, 0x400, 6 with MEM_ADDR_W=10. Expect beats mem[5] err=0, then 0 err=1, then mem[6] err=0. mem_ren is low during the 0x400 accept, and err_sticky=1 from the following cycle onward.
- Random in_valid/out_ready (50% each), 1000 addresses in range. Expect output order and data to match a scoreboard exactly, no FIFO overflow, and no beat lost or duplicated.
- Assert rst for one cycle with 3 beats queued and 1 in flight. Expect out_valid=0, beat_count=0 and err_sticky=0 the next cycle, and no stale beat after new traffic resumes.
- Preload beat_count near wrap by popping 2^32-1 beats (bench force), then pop 2. Expect beat_count to read 1.

Source files
------------

// File: rtl/mem_read_stage.sv
`default_nettype none
// ============================================================================
// mem_read_stage: accepts generator addresses, reads a single-port SRAM and
// returns data in order through a credit-managed output FIFO.
// Revision: 1.0
// ============================================================================
module mem_read_stage #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_W-1:0]     in_addr,
    output logic                  in_ready,
    output logic                  mem_ren,
    output logic [MEM_ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err,
    input  logic                  out_ready,
    output logic                  err_sticky,
    output logic [31:0]           beat_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] c_CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic                  inflight_v_q,   inflight_v_d;
    logic                  inflight_err_q, inflight_err_d;
    logic [CNT_W-1:0]      count_q,        count_d;
    logic [PTR_W-1:0]      wr_ptr_q,       wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,       rd_ptr_d;
    logic                  err_sticky_q,   err_sticky_d;
    logic [31:0]           beat_count_q,   beat_count_d;
    logic [DATA_W-1:0]     fifo_data_q [DEPTH];
    logic [DEPTH-1:0]      fifo_err_q;

    logic                  w_in_range;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W:0]        w_credits_used;

    // Credits count both queued entries and the read still on its way back,
    // so the FIFO can never be pushed while full.
    assign w_credits_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_v_q);
    assign in_ready       = !rst && (w_credits_used < c_CREDIT_LIMIT);

    assign w_in_range = (in_addr[ADDR_W-1:MEM_ADDR_W] == '0);
    assign w_accept   = in_valid && in_ready;
    assign w_push     = inflight_v_q;
    assign w_pop      = out_valid && out_ready;

    assign mem_ren   = w_accept && w_in_range;
    assign mem_raddr = in_addr[MEM_ADDR_W-1:0];

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_err    = out_valid ? fifo_err_q[rd_ptr_q] : 1'b0;
    assign err_sticky = err_sticky_q;
    assign beat_count = beat_count_q;

    always_comb begin
        inflight_v_d   = w_accept;
        inflight_err_d = w_accept && !w_in_range;
        err_sticky_d   = err_sticky_q || (w_accept && !w_in_range);
        beat_count_d   = beat_count_q + 32'(w_pop);
        wr_ptr_d       = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d       = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d        = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_v_q   <= 1'b0;
            inflight_err_q <= 1'b0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            err_sticky_q   <= 1'b0;
            beat_count_q   <= '0;
        end else begin
            inflight_v_q   <= inflight_v_d;
            inflight_err_q <= inflight_err_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            err_sticky_q   <= err_sticky_d;
            beat_count_q   <= beat_count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            fifo_data_q[wr_ptr_q] <= inflight_err_q ? '0 : mem_rdata;
            fifo_err_q[wr_ptr_q]  <= inflight_err_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_read_stage.sv
`default_nettype none
// tb_mem_read_stage: vector table plus scoreboard bench for mem_read_stage.
module tb_mem_read_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic        in_ready;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        err_sticky;
    logic [31:0] beat_count;

    mem_read_stage #(.ADDR_W(32), .MEM_ADDR_W(10), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
        .err_sticky(err_sticky), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [1024];
    always_ff @(posedge clk) if (mem_ren) mem_rdata <= sram[mem_raddr];

    typedef struct { logic [15:0] data; logic err; } beat_t;
    typedef struct { logic [31:0] addr; logic [15:0] data; logic err; } vec_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] exp_beats = '0;
    int          rdy_mode = 1;   // 0 low, 1 high, 2 random, 3 hand-driven
    bit          lat_arm = 0, acc_seen = 0, val_seen = 0, first_pop_seen = 0;
    int          acc_cyc = 0, val_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Output monitor: every popped beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && lat_arm && out_valid && !val_seen) begin
                val_seen = 1;
                val_cyc  = cyc;
            end
            if (!rst && out_valid && out_ready) begin
                if (!first_pop_seen) begin
                    first_pop_seen = 1;
                    first_pop_cyc  = cyc;
                end
                last_pop_cyc = cyc;
                exp_beats    = exp_beats + 32'd1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got data %h err %b, required no beat", out_data, out_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e.data));
                    chk("beat_err", 32'(out_err), 32'(e.err));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [15:0] ed, input logic ee);
        bit    ok;
        beat_t b;
        ok       = 0;
        in_valid = 1'b1;
        in_addr  = a;
        for (int g = 0; g < 500; g++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (lat_arm && !acc_seen) begin
                acc_seen = 1;
                acc_cyc  = cyc;
            end
            b.data = ed;
            b.err  = ee;
            exp_q.push_back(b);
            chk("mem_ren", 32'(mem_ren), 32'(!ee));
            if (!ee) chk("mem_raddr", 32'(mem_raddr), {22'd0, a[9:0]});
            chk("occupancy", 32'(exp_q.size() <= DEPTH), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        bit          sticky_seen;
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) sram[i] = 16'(i + 'h100);
        vecs[0] = '{32'h0000_0005, 16'h0105, 1'b0};
        vecs[1] = '{32'h0000_0400, 16'h0000, 1'b1};
        vecs[2] = '{32'h0000_0006, 16'h0106, 1'b0};
        vecs[3] = '{32'h0000_03FF, 16'h04FF, 1'b0};
        vecs[4] = '{32'h8000_0000, 16'h0000, 1'b1};
        vecs[5] = '{32'h0000_07FF, 16'h0000, 1'b1};

        // Reset values, with a valid address offered during reset
        rst = 1'b1; in_valid = 1'b1; in_addr = 32'h5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_ren", 32'(mem_ren), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_beat_count", beat_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Streaming 0..15 with out_ready high
        lat_arm = 1; first_pop_seen = 0;
        for (int i = 0; i < 16; i++) send(32'(i), 16'(i + 'h100), 1'b0);
        drain();
        lat_arm = 0;
        chk("latency", 32'(val_cyc - acc_cyc), 32'd2);
        chk("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd15);
        chk("stream_beat_count", beat_count, 32'd16);

        // Backpressure: exactly DEPTH accepts, then one pop frees a credit
        rdy_mode = 3; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i), 16'(i + 'h100), 1'b0);
        in_valid = 1'b1; in_addr = 32'h4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_head", 32'(out_data), 32'h100);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_pop_cycle", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_reassert", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back('{16'h0104, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        drain();
        chk("bp_beat_count", beat_count, exp_beats);

        // Range-check vectors
        @(negedge clk);
        chk("err_sticky_pre", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        sticky_seen = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].addr, vecs[i].data, vecs[i].err);
            if (vecs[i].err && !sticky_seen) begin
                sticky_seen = 1;
                @(negedge clk);
                chk("err_sticky_set", 32'(err_sticky), 32'd1);
                @(posedge clk); #1;
            end
        end
        drain();
        chk("err_sticky_hold", 32'(err_sticky), 32'd1);

        // Random valid/ready traffic against the scoreboard
        rdy_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send(a, sram[a[9:0]], 1'b0);
        end
        rdy_mode = 1;
        drain();
        chk("random_beat_count", beat_count, exp_beats);

        // Reset with three beats queued and one read in flight
        rdy_mode = 3; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(16 + i), 16'(16 + i + 'h100), 1'b0);
        rst = 1'b1;
        exp_q.delete();
        exp_beats = '0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beat_count", beat_count, 32'd0);
        chk("midrst_err_sticky", 32'(err_sticky), 32'd0);
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) send(32'(32 + i), 16'(32 + i + 'h100), 1'b0);
        drain();
        chk("midrst_new_beats", beat_count, 32'd3);

        // beat_count wrap
        force dut.beat_count_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.beat_count_q;
        exp_beats = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("wrap_preload", beat_count, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        send(32'd7, 16'h0107, 1'b0);
        send(32'd8, 16'h0108, 1'b0);
        drain();
        chk("wrap_beat_count", beat_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
